// File: rtl/if_pkg.sv
`default_nettype none
// ============================================================================
// Module   : if_pkg
// Purpose  : Shared types and constants for the instruction fetch unit.
//            Holds the fetch FSM state encoding, the NOP instruction that is
//            presented when the fetch queue is empty, and the {pc, inst}
//            queue entry type.
// Revision : 1.0 - initial release
// ============================================================================
package if_pkg;

  // Width of one fetch queue field (pc or inst).
  localparam int IF_XLEN = 32;

  // addi x0, x0, 0 -- presented on IF_inst when nothing is queued.
  localparam logic [IF_XLEN-1:0] IF_NOP = 32'h0000_0013;

  // Fetch FSM states:
  //   ST_IDLE  - no request outstanding
  //   ST_WAIT  - request outstanding, its data will be queued
  //   ST_DRAIN - request outstanding, its data will be thrown away
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_DRAIN = 2'd2
  } fetch_state_e;

  // One fetch queue entry.
  typedef struct packed {
    logic [IF_XLEN-1:0] pc;
    logic [IF_XLEN-1:0] inst;
  } fetch_entry_t;

endpackage : if_pkg
`default_nettype wire

// File: rtl/if_fetch_q.sv
`default_nettype none
// ============================================================================
// Module   : if_fetch_q
// Purpose  : Two-entry {pc, inst} FIFO between the fetch FSM and the IF/ID
//            consumer. Entry 0 is always the head; a pop shifts entry 1 down.
//            Push and pop in the same cycle both take effect. Flush empties
//            the queue and overrides push/pop.
// Ports    :
//   i_clk        in   rising-edge clock
//   i_rst        in   synchronous active-high reset (queue empty)
//   i_flush      in   discard all entries
//   i_push       in   append i_push_entry
//   i_push_entry in   entry to append
//   i_pop        in   remove head (ignored while empty)
//   o_count      out  number of valid entries (0..2)
//   o_head       out  head entry (don't-care while o_count == 0)
// Revision : 1.0 - initial release
// ============================================================================
module if_fetch_q
  import if_pkg::*;
(
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_flush,
  input  logic         i_push,
  input  fetch_entry_t i_push_entry,
  input  logic         i_pop,
  output logic [1:0]   o_count,
  output fetch_entry_t o_head
);

  fetch_entry_t slot0_q, slot0_d;
  fetch_entry_t slot1_q, slot1_d;
  logic [1:0]   count_q, count_d;

  logic         pop_ok;
  logic         push_ok;
  logic [1:0]   occ_after_pop;

  always_comb begin
    pop_ok        = i_pop && (count_q != 2'd0);
    // A full queue can still accept a push when the head leaves this cycle.
    push_ok       = i_push && ((count_q != 2'd2) || pop_ok);
    occ_after_pop = count_q - {1'b0, pop_ok};

    slot0_d = slot0_q;
    slot1_d = slot1_q;
    count_d = count_q;

    if (i_flush) begin
      count_d = 2'd0;
    end else begin
      if (pop_ok) begin
        slot0_d = slot1_q;
      end
      // The new entry lands in the first slot left free after the pop.
      if (push_ok) begin
        if (occ_after_pop == 2'd0) begin
          slot0_d = i_push_entry;
        end else begin
          slot1_d = i_push_entry;
        end
      end
      count_d = occ_after_pop + {1'b0, push_ok};
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      slot0_q <= '0;
      slot1_q <= '0;
      count_q <= 2'd0;
    end else begin
      slot0_q <= slot0_d;
      slot1_q <= slot1_d;
      count_q <= count_d;
    end
  end

  assign o_count = count_q;
  assign o_head  = slot0_q;

endmodule : if_fetch_q
`default_nettype wire

// File: rtl/if_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : if_fetch_unit
// Purpose  : Instruction fetch stage. Issues one outstanding request at a
//            time to instruction memory, buffers returned instructions in a
//            two-entry queue and presents the head to the decode stage.
//            Redirects flush the queue; a redirect that arrives while a
//            request is still outstanding marks that request's data for
//            discard (DRAIN) and re-fetches once it completes.
//
//            Build option IF_FETCH_MISALIGN_EN:
//              defined   - a redirect target with bits [1:0] != 0 raises
//                          o_misalign, flushes, idles and blocks fetching
//                          until the next aligned redirect or reset.
//              undefined - o_misalign is absent; redirect target bits [1:0]
//                          are forced to zero.
// Ports    :
//   i_clk          in   rising-edge clock
//   i_rst          in   synchronous active-high reset
//   i_stall        in   IF/ID buffer not accepting
//   i_redirect     in   branch/jump taken, flush fetch
//   i_redirect_pc  in   redirect target
//   o_imem_req     out  instruction memory request
//   o_imem_addr    out  request address (stable from issue to ack)
//   i_imem_ack     in   request accepted, rdata valid this cycle
//   i_imem_rdata   in   fetched instruction
//   IF_inst        out  head instruction (NOP when empty)
//   IF_pc          out  head PC (0 when empty)
//   IF_valid       out  queue non-empty
//   o_misalign     out  misaligned redirect flag (IF_FETCH_MISALIGN_EN only)
// Revision : 1.0 - initial release
// ============================================================================
module if_fetch_unit
  import if_pkg::*;
#(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_stall,
  input  logic             i_redirect,
  input  logic [WIDTH-1:0] i_redirect_pc,
  output logic             o_imem_req,
  output logic [WIDTH-1:0] o_imem_addr,
  input  logic             i_imem_ack,
  input  logic [WIDTH-1:0] i_imem_rdata,
  output logic [WIDTH-1:0] IF_inst,
  output logic [WIDTH-1:0] IF_pc,
  output logic             IF_valid
`ifdef IF_FETCH_MISALIGN_EN
  ,
  output logic             o_misalign
`endif
);

  fetch_state_e     state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] req_addr_q, req_addr_d;

  logic [WIDTH-1:0] tgt;
  logic             tgt_misaligned;
  logic             misalign_q;

  logic [1:0]       q_count;
  fetch_entry_t     q_head;
  fetch_entry_t     push_entry;
  logic             q_push;
  logic             q_pop;
  logic             q_flush;

  logic             ack_live;
  logic [1:0]       count_after;
  logic             issue_ok;

`ifdef IF_FETCH_MISALIGN_EN
  logic misalign_d;
  assign tgt            = i_redirect_pc;
  assign tgt_misaligned = |i_redirect_pc[1:0];
  assign o_misalign     = misalign_q;
`else
  assign tgt            = {i_redirect_pc[WIDTH-1:2], 2'b00};
  assign tgt_misaligned = 1'b0;
  assign misalign_q     = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // Queue control
  // --------------------------------------------------------------------------
  assign q_pop   = (q_count != 2'd0) && !i_stall;
  assign q_push  = (state_q == ST_WAIT) && i_imem_ack && !i_redirect;
  assign q_flush = i_redirect;

  assign push_entry.pc   = IF_XLEN'(req_addr_q);
  assign push_entry.inst = IF_XLEN'(i_imem_rdata);

  if_fetch_q u_fetch_q (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_flush      (q_flush),
    .i_push       (q_push),
    .i_push_entry (push_entry),
    .i_pop        (q_pop),
    .o_count      (q_count),
    .o_head       (q_head)
  );

  // --------------------------------------------------------------------------
  // Fetch FSM
  // --------------------------------------------------------------------------
  always_comb begin
    ack_live    = (state_q != ST_IDLE) && i_imem_ack;
    // Occupancy after this edge's push/pop; a new request is only launched
    // when its data is guaranteed a free slot.
    count_after = q_count - {1'b0, q_pop} + {1'b0, q_push};
    issue_ok    = (count_after <= 2'd1) && !misalign_q;

    state_d    = state_q;
    pc_d       = pc_q;
    req_addr_d = req_addr_q;
`ifdef IF_FETCH_MISALIGN_EN
    misalign_d = misalign_q;
`endif

    if (i_redirect) begin
      if (tgt_misaligned) begin
        // Drop any outstanding request; a later ack is ignored in IDLE.
        state_d = ST_IDLE;
`ifdef IF_FETCH_MISALIGN_EN
        misalign_d = 1'b1;
`endif
      end else begin
`ifdef IF_FETCH_MISALIGN_EN
        misalign_d = 1'b0;
`endif
        if ((state_q == ST_IDLE) || ack_live) begin
          // Memory port is free this edge: request the target right away.
          state_d    = ST_WAIT;
          req_addr_d = tgt;
          pc_d       = tgt + WIDTH'(4);
        end else begin
          // Old request still in flight: remember the target, wait it out.
          state_d = ST_DRAIN;
          pc_d    = tgt;
        end
      end
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (issue_ok) begin
            state_d    = ST_WAIT;
            req_addr_d = pc_q;
            pc_d       = pc_q + WIDTH'(4);
          end
        end
        ST_WAIT, ST_DRAIN: begin
          // WAIT data is pushed by q_push; DRAIN data is simply not pushed.
          if (i_imem_ack) begin
            if (issue_ok) begin
              state_d    = ST_WAIT;
              req_addr_d = pc_q;
              pc_d       = pc_q + WIDTH'(4);
            end else begin
              state_d = ST_IDLE;
            end
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= ST_IDLE;
      pc_q       <= RESET_PC;
      req_addr_q <= '0;
`ifdef IF_FETCH_MISALIGN_EN
      misalign_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_addr_q <= req_addr_d;
`ifdef IF_FETCH_MISALIGN_EN
      misalign_q <= misalign_d;
`endif
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign o_imem_req  = (state_q != ST_IDLE);
  assign o_imem_addr = req_addr_q;
  assign IF_valid    = (q_count != 2'd0);
  assign IF_pc       = IF_valid ? WIDTH'(q_head.pc)   : '0;
  assign IF_inst     = IF_valid ? WIDTH'(q_head.inst) : WIDTH'(IF_NOP);

endmodule : if_fetch_unit
`default_nettype wire

// File: tb/tb_if_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_if_fetch_unit
// Purpose  : Self-checking bench for if_fetch_unit: a directed vector table,
//            hand-written corner sequences and a randomized run compared
//            against a transaction-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_if_fetch_unit;

  localparam logic [31:0] NOP      = 32'h0000_0013;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst, stall, redirect, imem_ack;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr, imem_rdata;
  logic [31:0] if_inst, if_pc;
  logic        if_valid;
`ifdef IF_FETCH_MISALIGN_EN
  logic        misalign;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  // Instruction memory content is a fixed function of the address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  assign imem_rdata = mem_word(imem_addr);

  if_fetch_unit #(.WIDTH(32), .RESET_PC(RESET_PC)) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_stall       (stall),
    .i_redirect    (redirect),
    .i_redirect_pc (redirect_pc),
    .o_imem_req    (imem_req),
    .o_imem_addr   (imem_addr),
    .i_imem_ack    (imem_ack),
    .i_imem_rdata  (imem_rdata),
    .IF_inst       (if_inst),
    .IF_pc         (if_pc),
    .IF_valid      (if_valid)
`ifdef IF_FETCH_MISALIGN_EN
    ,
    .o_misalign    (misalign)
`endif
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
  endtask

  task automatic check_out(input string tag, input logic e_req, input logic [31:0] e_addr,
                           input logic e_valid, input logic [31:0] e_pc);
    check({tag, ".req"},   {31'b0, imem_req}, {31'b0, e_req});
    check({tag, ".addr"},  imem_addr, e_addr);
    check({tag, ".valid"}, {31'b0, if_valid}, {31'b0, e_valid});
    check({tag, ".pc"},    if_pc, e_valid ? e_pc : 32'h0);
    check({tag, ".inst"},  if_inst, e_valid ? mem_word(e_pc) : NOP);
  endtask

  // Called just after a falling edge; applies inputs across one rising edge.
  task automatic cycle(input logic r, input logic s, input logic rd,
                       input logic [31:0] rpc, input logic a);
    rst = r; stall = s; redirect = rd; redirect_pc = rpc; imem_ack = a;
    @(posedge clk);
    @(negedge clk);
  endtask

  // --------------------------------------------------------------------------
  // Directed vector table
  // --------------------------------------------------------------------------
  typedef struct {
    logic        rst, stall, redir;
    logic [31:0] rpc;
    logic        ack;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_pc;
  } vec_t;

  function automatic vec_t mkv(input logic r, input logic s, input logic rd,
                               input logic [31:0] rpc, input logic a,
                               input logic e_req, input logic [31:0] e_addr,
                               input logic e_valid, input logic [31:0] e_pc);
    vec_t v;
    v.rst = r; v.stall = s; v.redir = rd; v.rpc = rpc; v.ack = a;
    v.e_req = e_req; v.e_addr = e_addr; v.e_valid = e_valid; v.e_pc = e_pc;
    return v;
  endfunction

  // --------------------------------------------------------------------------
  // Reference model: one outstanding memory transaction plus a 2-deep queue
  // --------------------------------------------------------------------------
  typedef struct packed { logic [31:0] pc; logic [31:0] inst; } ent_t;
  ent_t        m_q[$];
  bit          m_live;   // a request is outstanding on the memory port
  bit          m_keep;   // its data belongs in the queue
  logic [31:0] m_raddr;
  logic [31:0] m_pc;
  bit          m_mis;

  task automatic model_step(input bit r, input bit s, input bit rd,
                            input logic [31:0] rpc, input bit a);
    logic [31:0] t;
    bit ackd;
    if (r) begin
      m_live = 0; m_keep = 0; m_pc = RESET_PC; m_raddr = 32'h0; m_mis = 0;
      m_q.delete();
      return;
    end
    ackd = m_live && a;
    if (rd) begin
      m_q.delete();
`ifdef IF_FETCH_MISALIGN_EN
      t = rpc;
      if (rpc[1:0] != 2'b00) begin
        m_mis = 1; m_live = 0;
        return;
      end
      m_mis = 0;
`else
      t = {rpc[31:2], 2'b00};
`endif
      if (!m_live || ackd) begin
        m_live = 1; m_keep = 1; m_raddr = t; m_pc = t + 32'd4;
      end else begin
        m_keep = 0; m_pc = t;
      end
      return;
    end
    if (m_q.size() > 0 && !s) void'(m_q.pop_front());
    if (ackd && m_keep) m_q.push_back({m_raddr, mem_word(m_raddr)});
    if (!m_live || ackd) begin
      if (!m_mis && m_q.size() + 1 <= 2) begin
        m_live = 1; m_keep = 1; m_raddr = m_pc; m_pc = m_pc + 32'd4;
      end else begin
        m_live = 0;
      end
    end
  endtask

  // --------------------------------------------------------------------------
  // Stimulus
  // --------------------------------------------------------------------------
  initial begin
    vec_t        vt[21];
    logic [31:0] popped[$];
    bit          r, s, rd, a;
    logic [31:0] rpc;

    rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0; imem_ack = 1'b0;
    @(negedge clk);

    // ---- table: reset, streaming, stall fill, redirect corners ----
    vt[0]  = mkv(1, 0, 0, 32'h0,   0,  0, 32'h0,   0, 32'h0);
    vt[1]  = mkv(0, 0, 0, 32'h0,   0,  1, 32'h0,   0, 32'h0);
    vt[2]  = mkv(0, 0, 0, 32'h0,   1,  1, 32'h4,   1, 32'h0);
    vt[3]  = mkv(0, 0, 0, 32'h0,   1,  1, 32'h8,   1, 32'h4);
    vt[4]  = mkv(0, 0, 0, 32'h0,   1,  1, 32'hC,   1, 32'h8);
    vt[5]  = mkv(0, 0, 0, 32'h0,   1,  1, 32'h10,  1, 32'hC);
    vt[6]  = mkv(0, 1, 0, 32'h0,   1,  0, 32'h10,  1, 32'hC);
    vt[7]  = mkv(0, 1, 0, 32'h0,   0,  0, 32'h10,  1, 32'hC);
    vt[8]  = mkv(0, 1, 0, 32'h0,   0,  0, 32'h10,  1, 32'hC);
    vt[9]  = mkv(0, 0, 0, 32'h0,   0,  1, 32'h14,  1, 32'h10);
    vt[10] = mkv(0, 0, 0, 32'h0,   1,  1, 32'h18,  1, 32'h14);
    vt[11] = mkv(0, 0, 1, 32'h100, 1,  1, 32'h100, 0, 32'h0);
    vt[12] = mkv(0, 0, 0, 32'h0,   0,  1, 32'h100, 0, 32'h0);
    vt[13] = mkv(0, 0, 1, 32'h200, 0,  1, 32'h100, 0, 32'h0);
    vt[14] = mkv(0, 0, 0, 32'h0,   1,  1, 32'h200, 0, 32'h0);
    vt[15] = mkv(0, 0, 0, 32'h0,   1,  1, 32'h204, 1, 32'h200);
    vt[16] = mkv(1, 0, 0, 32'h0,   0,  0, 32'h0,   0, 32'h0);
    vt[17] = mkv(0, 0, 0, 32'h0,   0,  1, 32'h0,   0, 32'h0);
    vt[18] = mkv(0, 0, 1, 32'h300, 0,  1, 32'h0,   0, 32'h0);
    vt[19] = mkv(0, 0, 0, 32'h0,   1,  1, 32'h300, 0, 32'h0);
    vt[20] = mkv(0, 0, 0, 32'h0,   1,  1, 32'h304, 1, 32'h300);
    for (int i = 0; i < 21; i++) begin
      cycle(vt[i].rst, vt[i].stall, vt[i].redir, vt[i].rpc, vt[i].ack);
      check_out($sformatf("vec%0d", i), vt[i].e_req, vt[i].e_addr, vt[i].e_valid, vt[i].e_pc);
    end

    // ---- late ack with redirect in the 2nd wait cycle ----
    cycle(1, 0, 0, 32'h0, 0);
    cycle(0, 0, 0, 32'h0, 0);
    check_out("drain.issue", 1, 32'h0, 0, 32'h0);
    cycle(0, 0, 0, 32'h0, 0);
    check_out("drain.wait1", 1, 32'h0, 0, 32'h0);
    cycle(0, 0, 1, 32'h100, 0);
    check_out("drain.redir", 1, 32'h0, 0, 32'h0);
    cycle(0, 0, 0, 32'h0, 1);
    check_out("drain.late", 1, 32'h100, 0, 32'h0);
    cycle(0, 0, 0, 32'h0, 1);
    check_out("drain.first", 1, 32'h104, 1, 32'h100);

    // ---- stall for 5 cycles with ack tied to req: nothing lost or doubled ----
    cycle(1, 0, 0, 32'h0, 0);
    popped.delete();
    for (int i = 0; i < 17; i++) begin
      s = (i >= 6 && i < 11);
      if (s) begin
        check($sformatf("stall%0d.valid", i), {31'b0, if_valid}, 32'h1);
        check($sformatf("stall%0d.head", i), if_pc, 32'(4 * popped.size()));
      end
      if (if_valid && !s) popped.push_back(if_pc);
      cycle(0, s, 0, 32'h0, imem_req);
      if (i == 10) check("stall.req_dropped", {31'b0, imem_req}, 32'h0);
    end
    check("stall.pop_count", {31'b0, popped.size() >= 10}, 32'h1);
    for (int i = 0; i < popped.size(); i++)
      check($sformatf("stall.order%0d", i), popped[i], 32'(4 * i));

    // ---- misaligned redirect target ----
    cycle(1, 0, 0, 32'h0, 0);
    cycle(0, 0, 0, 32'h0, 0);
    cycle(0, 0, 0, 32'h0, 1);
`ifdef IF_FETCH_MISALIGN_EN
    cycle(0, 0, 1, 32'h102, 1);
    check("mis.flag", {31'b0, misalign}, 32'h1);
    check_out("mis.blocked", 0, 32'h4, 0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      cycle(0, 0, 0, 32'h0, 0);
      check($sformatf("mis.hold%0d", i), {31'b0, imem_req}, 32'h0);
    end
    cycle(0, 0, 1, 32'h200, 0);
    check("mis.clear", {31'b0, misalign}, 32'h0);
    check_out("mis.refetch", 1, 32'h200, 0, 32'h0);
    cycle(0, 0, 0, 32'h0, 1);
    check_out("mis.first", 1, 32'h204, 1, 32'h200);
`else
    cycle(0, 0, 1, 32'h102, 1);
    check_out("align.forced", 1, 32'h100, 0, 32'h0);
    cycle(0, 0, 0, 32'h0, 1);
    check_out("align.first", 1, 32'h104, 1, 32'h100);
`endif

    // ---- randomized run against the reference model ----
    for (int i = 0; i < 1500; i++) begin
      r  = (i == 0) || ($urandom_range(0, 199) == 0);
      s  = ($urandom_range(0, 9) < 3);
      rd = ($urandom_range(0, 19) == 0);
      a  = ($urandom_range(0, 9) < 7);
      case ($urandom_range(0, 3))
        0:       rpc = $urandom;
        1:       rpc = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
        default: rpc = 32'($urandom_range(0, 255));
      endcase
      model_step(r, s, rd, rpc, a);
      cycle(r, s, rd, rpc, a);
      check_out($sformatf("rnd%0d", i), m_live, m_raddr, m_q.size() > 0,
                (m_q.size() > 0) ? m_q[0].pc : 32'h0);
`ifdef IF_FETCH_MISALIGN_EN
      check($sformatf("rnd%0d.mis", i), {31'b0, misalign}, {31'b0, m_mis});
`endif
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_if_fetch_unit
`default_nettype wire
